// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor
//
// Multi-cycle WIDTH-bit subtractor: f = a - b - bin, computed one SLICE-bit
// slice per clock, least significant slice first, with the borrow rippled
// between slices as an inverted carry (a + ~b + ~bin).
//
// Optional feature macro: ADDSUB_MODE_EN
//   When defined, a 'sub' input selects subtraction (1) or addition (0),
//   latched together with the operands. When undefined the block always
//   subtracts and there is no 'sub' port.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   sub    in   (ADDSUB_MODE_EN only) 1 = subtract, 0 = add
//   start  in   operation request, sampled only in IDLE
//   a      in   minuend (WIDTH)
//   b      in   subtrahend (WIDTH)
//   bin    in   borrow-in (carry-in in add mode)
//   busy   out  high while slices are being processed
//   done   out  one-cycle pulse; f/bout/ovf valid from this cycle
//   f      out  result (WIDTH), held until next completion or reset
//   bout   out  borrow-out (carry-out in add mode)
//   ovf    out  two's-complement overflow
//
// FSM states:
//   state | meaning
//   IDLE  | waiting for start; operands latched when start is seen
//   CALC  | one slice processed per cycle, last slice loads the outputs
//   DONE  | one-cycle completion, done pulses here

module nibble_serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef ADDSUB_MODE_EN
  input  logic             sub,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] f,
  output logic             bout,
  output logic             ovf
);

  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic             carry;

  // Mode of the operation in flight and mode requested at the inputs.
  logic             sub_mode;
  logic             sub_req;

`ifdef ADDSUB_MODE_EN
  logic             sub_q;
  assign sub_mode = sub_q;
  assign sub_req  = sub;
`else
  assign sub_mode = 1'b1;
  assign sub_req  = 1'b1;
`endif

  // Slice datapath
  int               idx;
  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic [SLICE:0]   slice_sum;
  logic [WIDTH-1:0] acc_next;
  logic             bout_next;
  logic             ovf_next;

  always_comb begin
    idx       = int'(cnt) * SLICE;
    slice_a   = a_q[idx +: SLICE];
    slice_b   = sub_mode ? ~b_q[idx +: SLICE] : b_q[idx +: SLICE];
    slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + {{SLICE{1'b0}}, carry};

    // The last slice bypasses acc so the outputs load on the same edge.
    acc_next                = acc;
    acc_next[idx +: SLICE]  = slice_sum[SLICE-1:0];

    // Carry out of the top slice is an inverted borrow when subtracting.
    bout_next = sub_mode ? ~slice_sum[SLICE] : slice_sum[SLICE];

    if (sub_mode)
      ovf_next = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                 (acc_next[WIDTH-1] != a_q[WIDTH-1]);
    else
      ovf_next = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                 (acc_next[WIDTH-1] != a_q[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      carry <= 1'b0;
`ifdef ADDSUB_MODE_EN
      sub_q <= 1'b1;
`endif
      busy  <= 1'b0;
      done  <= 1'b0;
      f     <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a;
            b_q   <= b;
`ifdef ADDSUB_MODE_EN
            sub_q <= sub;
`endif
            carry <= sub_req ? ~bin : bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end

        CALC: begin
          acc   <= acc_next;
          carry <= slice_sum[SLICE];
          if (cnt == LAST) begin
            cnt   <= '0;
            f     <= acc_next;
            bout  <= bout_next;
            ovf   <= ovf_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/nibble_serial_subtractor.md
Name: nibble_serial_subtractor

Overview:
- Multi-cycle 16-bit subtractor: computes f = a - b - bin one 4-bit slice per clock, LSB slice first, rippling the borrow between slices.
- It is the inverse-direction companion of the single-cycle 16-bit lookahead adder. It serves datapath paths that trade latency for area.
- Uses a start/busy/done handshake. Results are registered and held until the next operation.

Parameters:
- WIDTH, 16, operand and result width; must be a multiple of SLICE.
- SLICE, 4, bits processed per cycle. N = WIDTH/SLICE (N = 4 at defaults).

Ports:
- clk  input  1  clock, rising-edge active.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  single-cycle pulse; f/bout/ovf are valid from this cycle.
- f  output  WIDTH  difference.
- bout  output  1  borrow-out; 1 when unsigned a < b + bin.
- ovf  output  1  signed (two's complement) overflow.

Behaviour:
- Reset: one clock, synchronous active-low. rst_n=0 at a rising edge forces:
  - state = IDLE, slice counter = 0, internal accumulator = 0;
  - busy = 0, done = 0, f = 0, bout = 0, ovf = 0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - start=1 at edge E0 latches a, b and bin.
  - Internal carry is initialised to ~bin.
  - Counter = 0, state -> CALC, busy = 1.
  - start=0: remain in IDLE.
- CALC:
  - Edges E1..EN each process one slice k = counter, using slice = a[k] + ~b[k] + carry.
  - The slice sum goes into accumulator slice k; the slice carry-out becomes the next carry.
  - The counter increments after each slice.
  - At EN, the final slice is written straight into the output registers:
    - f = full accumulated result;
    - bout = ~final carry;
    - ovf = (a[MSB] != b[MSB]) && (f[MSB] != a[MSB]);
    - state -> DONE, done = 1, busy = 0.
- DONE:
  - Lasts exactly one cycle; edge EN+1 returns to IDLE with done = 0.
  - f, bout and ovf hold their values until the next completion or a reset.
- Latency: done is high in the cycle after edge E0+N, i.e. 4 cycles after start is sampled at defaults. Throughput is one operation per N+2 cycles.
- start in CALC or DONE is ignored and is not queued. Latched operands are unaffected by later changes on a/b/bin.
- Outputs f/bout/ovf do not change during CALC; only the internal accumulator updates.
- Reset mid-CALC: the operation is aborted, done never pulses, outputs are cleared to 0.
- Wrap-around: the result is modulo 2^WIDTH (e.g. 0x0000 - 0x0001 = 0xFFFF, bout = 1).

Optional Feature:
- Macro: ADDSUB_MODE_EN.
- Defined:
  - Adds input port sub (1 bit), latched at E0 alongside the operands.
  - sub=1 behaves exactly as above.
  - sub=0 performs addition f = a + b + bin: slice operand is b[k] (not inverted), initial carry is bin, bout reports carry-out directly.
  - In add mode, ovf = (a[MSB] == b[MSB]) && (f[MSB] != a[MSB]).
  - Latency and handshake are identical to subtract mode.
- Undefined: no sub port; the block always subtracts.

Test Plan:
- Subtract, no borrow: a=0x3333, b=0x1111, bin=0, start pulse.
  - Expect busy for 4 cycles, then done pulse 4 cycles after start.
  - Expect f=0x2222, bout=0, ovf=0.
- Borrow out: a=0x1111, b=0x3333, bin=0 -> f=0xDDDE, bout=1, ovf=0.
- Borrow-in propagating through all slices: a=0x0000, b=0x0000, bin=1 -> f=0xFFFF, bout=1, ovf=0.
- Signed overflow: a=0x8000, b=0x0001, bin=0 -> f=0x7FFF, bout=0, ovf=1.
- Handshake and reset edges:
  - Pulse start with a=0x5555, b=0x7777 during CALC of a 0x3333-0x1111 operation -> ignored; result stays f=0x2222.
  - Assert rst_n=0 for one edge mid-CALC -> next cycle busy=0, no done pulse, f=0, bout=0, ovf=0.
- With ADDSUB_MODE_EN defined: sub=0, a=0xFFFF, b=0xFFFF, bin=1 -> f=0xFFFF, bout=1, ovf=0. Then sub=1 with the same operands -> f=0xFFFF, bout=1, ovf=0.
